// File: rtl/not_gate.sv
// Bitwise inverter with a registered copy of the inverted value and a saturating
// counter of sampled input changes, for debug observability.
module not_gate #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_sat
);

    logic [WIDTH-1:0] yq_q;
    logic [WIDTH-1:0] a_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             toggled;
    logic             cnt_max;

    // Purely combinational: valid regardless of clk/rst state.
    assign y = ~a;

    always_comb begin
        toggled = (a != a_prev_q);
        cnt_max = &cnt_q;
        cnt_d   = cnt_q;
        if (toggled && !cnt_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Once the count reaches all ones it can never leave, so sat follows it.
        sat_d = sat_q | (&cnt_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            yq_q     <= '1;
            a_prev_q <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            yq_q     <= ~a;
            a_prev_q <= a;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
        end
    end

    assign y_q        = yq_q;
    assign toggle_cnt = cnt_q;
    assign cnt_sat    = sat_q;

endmodule

// File: tb/tb_not_gate.sv
// Self-checking bench for not_gate: table-driven vectors with a scoreboard queue
// across three configurations (1-bit, 1-bit with 2-bit counter, 8-bit).
module tb_not_gate;

    typedef struct {
        logic [7:0]  y_q;
        logic [15:0] cnt;
        logic        sat;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        exp_t       e;
    } vec_t;

    logic clk;
    logic rst;

    // Instance 0: clk/rst deliberately never driven.
    logic        clk0, rst0;
    logic        a0, y0, yq0, sat0;
    logic [15:0] cnt0;

    logic        a1, y1, yq1, sat1;
    logic [15:0] cnt1;

    logic        a2, y2, yq2, sat2;
    logic [1:0]  cnt2;

    logic [7:0]  a3, y3, yq3;
    logic        sat3;
    logic [15:0] cnt3;

    int n_cmp  = 0;
    int n_fail = 0;
    exp_t sb[$];

    not_gate #(.WIDTH(1), .CNT_W(16)) u0 (
        .clk(clk0), .rst(rst0), .a(a0), .y(y0), .y_q(yq0), .toggle_cnt(cnt0), .cnt_sat(sat0)
    );
    not_gate #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .a(a1), .y(y1), .y_q(yq1), .toggle_cnt(cnt1), .cnt_sat(sat1)
    );
    not_gate #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .a(a2), .y(y2), .y_q(yq2), .toggle_cnt(cnt2), .cnt_sat(sat2)
    );
    not_gate #(.WIDTH(8), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .a(a3), .y(y3), .y_q(yq3), .toggle_cnt(cnt3), .cnt_sat(sat3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int d, input logic [7:0] av);
        case (d)
            1:       a1 = av[0];
            2:       a2 = av[0];
            default: a3 = av;
        endcase
    endtask

    task automatic sample(input int d, output logic [7:0] yc, output logic [7:0] yq,
                          output logic [15:0] cnt, output logic sat);
        case (d)
            1:       begin yc = {7'b0, y1}; yq = {7'b0, yq1}; cnt = cnt1;         sat = sat1; end
            2:       begin yc = {7'b0, y2}; yq = {7'b0, yq2}; cnt = {14'b0, cnt2}; sat = sat2; end
            default: begin yc = y3;         yq = yq3;         cnt = cnt3;         sat = sat3; end
        endcase
    endtask

    // Drive one input, check the combinational path, then check registered state after the edge.
    task automatic cycle(input int d, input string name, input logic [7:0] av, input exp_t e);
        logic [7:0]  yc, yq, yexp;
        logic [15:0] cnt;
        logic        sat;
        exp_t        got;
        apply(d, av);
        #1;
        yexp = (d == 3) ? ~av : {7'b0, ~av[0]};
        sample(d, yc, yq, cnt, sat);
        check({name, ".y"}, 32'(yc), 32'(yexp));
        sb.push_back(e);
        @(posedge clk);
        #1;
        sample(d, yc, yq, cnt, sat);
        if (sb.size() == 0) begin
            check({name, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({name, ".y_q"}, 32'(yq), 32'(got.y_q));
            check({name, ".cnt"}, 32'(cnt), 32'(got.cnt));
            check({name, ".sat"}, 32'(sat), 32'(got.sat));
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    vec_t toggle_tab[5];
    vec_t sat_tab[5];

    initial begin
        logic [7:0]  ra, prev;
        logic [15:0] mcnt;
        exp_t        e;

        toggle_tab[0] = '{a: 8'd1, e: '{y_q: 8'd0, cnt: 16'd1, sat: 1'b0}};
        toggle_tab[1] = '{a: 8'd1, e: '{y_q: 8'd0, cnt: 16'd1, sat: 1'b0}};
        toggle_tab[2] = '{a: 8'd0, e: '{y_q: 8'd1, cnt: 16'd2, sat: 1'b0}};
        toggle_tab[3] = '{a: 8'd1, e: '{y_q: 8'd0, cnt: 16'd3, sat: 1'b0}};
        toggle_tab[4] = '{a: 8'd1, e: '{y_q: 8'd0, cnt: 16'd3, sat: 1'b0}};

        sat_tab[0] = '{a: 8'd1, e: '{y_q: 8'd0, cnt: 16'd1, sat: 1'b0}};
        sat_tab[1] = '{a: 8'd0, e: '{y_q: 8'd1, cnt: 16'd2, sat: 1'b0}};
        sat_tab[2] = '{a: 8'd1, e: '{y_q: 8'd0, cnt: 16'd3, sat: 1'b1}};
        sat_tab[3] = '{a: 8'd0, e: '{y_q: 8'd1, cnt: 16'd3, sat: 1'b1}};
        sat_tab[4] = '{a: 8'd1, e: '{y_q: 8'd0, cnt: 16'd3, sat: 1'b1}};

        a1 = 1'b0;
        a2 = 1'b0;
        a3 = 8'h00;
        rst = 1'b0;

        // Inverter with clock and reset undriven.
        a0 = 1'b0;
        #1;
        if (y0 !== 1'b1) begin
            $display("FAIL undriven.y0: got %b, expected 1", y0);
            $fatal(1, "inverter broken with undriven clk/rst");
        end
        n_cmp++;
        a0 = 1'b1;
        #1;
        if (y0 !== 1'b0) begin
            $display("FAIL undriven.y1: got %b, expected 0", y0);
            $fatal(1, "inverter broken with undriven clk/rst");
        end
        n_cmp++;

        // Asynchronous reset between clock edges (t=2..4, next edge at t=5).
        rst = 1'b1;
        a1  = 1'b1;
        #1;
        check("rst.y_q", 32'(yq1), 32'd1);
        check("rst.cnt", 32'(cnt1), 32'd0);
        check("rst.sat", 32'(sat1), 32'd0);
        check("rst.y_during_rst", 32'(y1), 32'd0);
        check("rst.y_q8", 32'(yq3), 32'hFF);
        a1 = 1'b0;
        #1;
        check("rst.y_after_a0", 32'(y1), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Registered path latency.
        cycle(1, "reg0", 8'd1, '{y_q: 8'd0, cnt: 16'd1, sat: 1'b0});
        cycle(1, "reg1", 8'd0, '{y_q: 8'd1, cnt: 16'd2, sat: 1'b0});

        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, $sformatf("tog%0d", i), toggle_tab[i].a, toggle_tab[i].e);
        end

        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(2, $sformatf("sat%0d", i), sat_tab[i].a, sat_tab[i].e);
        end

        // 8-bit path, then reset mid-stream.
        pulse_reset();
        cycle(3, "w8", 8'hA5, '{y_q: 8'h5A, cnt: 16'd1, sat: 1'b0});
        rst = 1'b1;
        #1;
        check("w8rst.y_q", 32'(yq3), 32'hFF);
        check("w8rst.cnt", 32'(cnt3), 32'd0);
        check("w8rst.sat", 32'(sat3), 32'd0);
        check("w8rst.y", 32'(y3), 32'h5A);
        rst = 1'b0;

        // Random stimulus against a reference model; a_prev restarts at 0 after reset.
        prev = 8'h00;
        mcnt = 16'd0;
        for (int i = 0; i < 24; i++) begin
            ra = (i % 4 == 3) ? prev : 8'($urandom_range(0, 255));
            if (ra != prev && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            e = '{y_q: ~ra, cnt: mcnt, sat: (mcnt == 16'hFFFF)};
            prev = ra;
            cycle(3, $sformatf("rnd%0d", i), ra, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
